// File: rtl/signal_ctrl_pkg.sv
// rtl/signal_ctrl_pkg.sv - light/phase codes and round-robin road picker for the signal controller
package signal_ctrl_pkg;

  localparam logic [1:0] LIGHT_RED    = 2'd0;
  localparam logic [1:0] LIGHT_YELLOW = 2'd1;
  localparam logic [1:0] LIGHT_GREEN  = 2'd2;

  typedef enum logic [1:0] {
    PH_ALL_RED = 2'd0,
    PH_GREEN   = 2'd1,
    PH_YELLOW  = 2'd2
  } phase_e;

  // Returns {hit, index}: first set request scanning cur+1, cur+2, ... mod n,
  // so the road that was just served is checked last.
  function automatic logic [3:0] rr_pick(input logic [7:0] req, input logic [2:0] cur, input int n);
    logic [3:0] res;
    int         idx;
    res = 4'd0;
    for (int k = 1; k <= 8; k++) begin
      if (k <= n && !res[3]) begin
        idx = (int'(cur) + k) % n;
        if (req[idx[2:0]]) res = {1'b1, idx[2:0]};
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/signal_tick_gen.sv
// rtl/signal_tick_gen.sv - prescaler producing a one-cycle timing tick every TICK_DIV clocks
module signal_tick_gen #(
  parameter int TICK_DIV = 50000000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)               r_cnt <= '0;
    else if (r_cnt == LAST) r_cnt <= '0;
    else                    r_cnt <= r_cnt + 1'b1;
  end

  // Gated by reset so a divide-by-one prescaler still reads 0 while held in reset.
  assign tick = rst && (r_cnt == LAST);

endmodule

// File: rtl/multi_road_signal_controller.sv
// rtl/multi_road_signal_controller.sv - N-road round-robin intersection controller; EMERGENCY_PREEMPT_EN adds preemption
// Timing is counted in prescaled ticks; lights/phase/cur_road lag the state register by one clock.
module multi_road_signal_controller
  import signal_ctrl_pkg::*;
#(
  parameter int NUM_ROADS = 4,
  parameter int TICK_DIV  = 50000000,
  parameter int MIN_GREEN = 10,
  parameter int MAX_GREEN = 30,
  parameter int YELLOW_T  = 3,
  parameter int ALL_RED_T = 2,
  parameter int TIMER_W   = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_ROADS-1:0]   car_det,
`ifdef EMERGENCY_PREEMPT_EN
  input  logic                   emerg_req,
  input  logic [2:0]             emerg_road,
`endif
  output logic [2*NUM_ROADS-1:0] lights,
  output logic [2:0]             cur_road,
  output logic [1:0]             phase,
  output logic                   tick
);

  localparam logic [TIMER_W-1:0]   T_MIN    = TIMER_W'(MIN_GREEN);
  localparam logic [TIMER_W-1:0]   T_MAX    = TIMER_W'(MAX_GREEN);
  localparam logic [TIMER_W-1:0]   T_YEL    = TIMER_W'(YELLOW_T);
  localparam logic [TIMER_W-1:0]   T_ALLRED = TIMER_W'(ALL_RED_T);
  localparam logic [NUM_ROADS-1:0] ONE_HOT0 = 1;

  logic [NUM_ROADS-1:0]   r_car_meta, r_car_sync, r_req_pend;
  phase_e                 r_state, w_state_nxt;
  logic [TIMER_W-1:0]     r_timer, w_timer_nxt, w_elapsed;
  logic [2:0]             r_cur, w_cur_nxt;
  logic [2*NUM_ROADS-1:0] r_lights, w_lights_nxt;
  logic [1:0]             r_phase;
  logic [2:0]             r_cur_out;
  logic [NUM_ROADS-1:0]   w_cur_mask, w_green_mask, w_clr_mask;
  logic [3:0]             w_pick;
  logic                   w_tick, w_other, w_cur_car, w_enter_green;
  logic                   w_em;
  logic [2:0]             w_em_road;

  signal_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .tick (w_tick)
  );

`ifdef EMERGENCY_PREEMPT_EN
  logic       r_em_meta, r_em_sync;
  logic [2:0] r_emr_meta, r_emr_sync;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_em_meta  <= 1'b0;
      r_em_sync  <= 1'b0;
      r_emr_meta <= 3'd0;
      r_emr_sync <= 3'd0;
    end else begin
      r_em_meta  <= emerg_req;
      r_em_sync  <= r_em_meta;
      r_emr_meta <= emerg_road;
      r_emr_sync <= r_emr_meta;
    end
  end

  assign w_em      = r_em_sync;
  assign w_em_road = r_emr_sync;
`else
  assign w_em      = 1'b0;
  assign w_em_road = 3'd0;
`endif

  assign w_elapsed    = (r_timer == '1) ? r_timer : r_timer + 1'b1;
  assign w_cur_mask   = ONE_HOT0 << r_cur;
  assign w_other      = |(r_req_pend & ~w_cur_mask);
  assign w_cur_car    = |(r_car_sync & w_cur_mask);
  assign w_pick       = rr_pick(8'(r_req_pend), r_cur, NUM_ROADS);
  assign w_green_mask = (r_state == PH_GREEN) ? w_cur_mask : '0;
  assign w_clr_mask   = w_enter_green ? (ONE_HOT0 << w_cur_nxt) : '0;

  always_comb begin
    w_state_nxt   = r_state;
    w_timer_nxt   = w_tick ? w_elapsed : r_timer;
    w_cur_nxt     = r_cur;
    w_enter_green = 1'b0;
    case (r_state)
      PH_ALL_RED: begin
        if (w_tick && w_elapsed >= T_ALLRED && (w_em || w_pick[3])) begin
          w_cur_nxt     = w_em ? w_em_road : w_pick[2:0];
          w_state_nxt   = PH_GREEN;
          w_timer_nxt   = '0;
          w_enter_green = 1'b1;
        end
      end
      PH_GREEN: begin
        if (w_em && w_em_road != r_cur) begin
          w_state_nxt = PH_YELLOW;
          w_timer_nxt = '0;
        end else if (w_tick && !w_em && w_elapsed >= T_MIN && w_other &&
                     (!w_cur_car || w_elapsed >= T_MAX)) begin
          w_state_nxt = PH_YELLOW;
          w_timer_nxt = '0;
        end
      end
      PH_YELLOW: begin
        if (w_tick && w_elapsed >= T_YEL) begin
          w_state_nxt = PH_ALL_RED;
          w_timer_nxt = '0;
        end
      end
      default: begin
        w_state_nxt = PH_ALL_RED;
        w_timer_nxt = '0;
      end
    endcase
  end

  always_comb begin
    w_lights_nxt = '0;
    for (int i = 0; i < NUM_ROADS; i++) begin
      if (3'(i) == r_cur) begin
        if (r_state == PH_GREEN)       w_lights_nxt[2*i +: 2] = LIGHT_GREEN;
        else if (r_state == PH_YELLOW) w_lights_nxt[2*i +: 2] = LIGHT_YELLOW;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_car_meta <= '0;
      r_car_sync <= '0;
      r_req_pend <= '0;
      r_state    <= PH_ALL_RED;
      r_timer    <= '0;
      r_cur      <= 3'(NUM_ROADS - 1);
      r_lights   <= '0;
      r_phase    <= PH_ALL_RED;
      r_cur_out  <= 3'(NUM_ROADS - 1);
    end else begin
      r_car_meta <= car_det;
      r_car_sync <= r_car_meta;
      // Clear wins over set so the road entering green drops its own request.
      r_req_pend <= (r_req_pend | (r_car_sync & ~w_green_mask)) & ~w_clr_mask;
      r_state    <= w_state_nxt;
      r_timer    <= w_timer_nxt;
      r_cur      <= w_cur_nxt;
      r_lights   <= w_lights_nxt;
      r_phase    <= r_state;
      r_cur_out  <= r_cur;
    end
  end

  assign lights   = r_lights;
  assign phase    = r_phase;
  assign cur_road = r_cur_out;
  assign tick     = w_tick;

endmodule

// File: tb/tb_multi_road_signal_controller.sv
// tb/tb_multi_road_signal_controller.sv - scoreboard bench for the N-road signal controller
module tb_multi_road_signal_controller;

  localparam int NR = 4, TD = 4, MING = 3, MAXG = 6, YT = 2, ART = 1;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [NR-1:0]   car_det = '0;
  logic [2*NR-1:0] lights;
  logic [2:0]      cur_road;
  logic [1:0]      phase;
  logic            tick;
`ifdef EMERGENCY_PREEMPT_EN
  logic            emerg_req = 1'b0;
  logic [2:0]      emerg_road = 3'd0;
`endif

  typedef struct packed {
    logic [7:0] l;
    logic [1:0] p;
    logic [2:0] c;
  } obs_t;

  obs_t q[$];
  int   n_checks = 0;
  int   n_err    = 0;
  bit   mon_en   = 1'b0;

  always #5 clk = ~clk;

  multi_road_signal_controller #(
    .NUM_ROADS(NR), .TICK_DIV(TD), .MIN_GREEN(MING), .MAX_GREEN(MAXG),
    .YELLOW_T(YT), .ALL_RED_T(ART), .TIMER_W(8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .car_det    (car_det),
`ifdef EMERGENCY_PREEMPT_EN
    .emerg_req  (emerg_req),
    .emerg_road (emerg_road),
`endif
    .lights     (lights),
    .cur_road   (cur_road),
    .phase      (phase),
    .tick       (tick)
  );

  task automatic expect_state(input logic [7:0] l, input logic [1:0] p, input logic [2:0] c);
    q.push_back(obs_t'({l, p, c}));
  endtask

  task automatic check_state(input string tag);
    obs_t e, a;
    e = q.pop_front();
    a = obs_t'({lights, phase, cur_road});
    n_checks++;
    assert (a === e) else begin
      n_err++;
      $error("FAIL %s: observed lights=%h phase=%0d cur_road=%0d, expected lights=%h phase=%0d cur_road=%0d",
             tag, a.l, a.p, a.c, e.l, e.p, e.c);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_state(input logic [1:0] p, input bit use_cur, input logic [2:0] c,
                            input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (phase === p && (!use_cur || cur_road === c)) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Called on the first sample of phase p; leaves the bench on the first sample of the next phase.
  task automatic measure(input logic [1:0] p, input int bound, output int n);
    n = 1;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (phase !== p) break;
      n++;
    end
  endtask

  always @(negedge clk) begin
    int nz;
    bit bad;
    if (mon_en && rst) begin
      nz  = 0;
      bad = 1'b0;
      for (int i = 0; i < NR; i++) begin
        if (lights[2*i +: 2] != 2'd0) nz++;
        if (lights[2*i +: 2] == 2'd3) bad = 1'b1;
      end
      n_checks++;
      assert (nz <= 1 && !bad) else begin
        n_err++;
        $error("FAIL lamp_exclusive: observed lights=%h, expected at most one non-RED road and no code 3", lights);
      end
    end
  end

  initial begin
    bit ok;
    int n, ticks;

    rst = 1'b0;
    repeat (3) @(negedge clk);
    expect_state(8'h00, 2'd0, 3'd3); check_state("reset_state");
    check_int("reset_tick", int'(tick), 0);
    rst = 1'b1;
    mon_en = 1'b1;

    ticks = 0;
    ok = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      ticks += int'(tick);
      if (phase !== 2'd0 || lights !== 8'h00) ok = 1'b0;
    end
    check_int("idle_tick_count", ticks, 200 / TD);
    check_int("idle_all_red_held", int'(ok), 1);
    expect_state(8'h00, 2'd0, 3'd3); check_state("idle_state");

    car_det = 4'b0100;
    repeat (3) @(negedge clk);
    car_det = 4'b0000;
    wait_state(2'd1, 1'b0, 3'd0, 30, ok);
    check_int("s2_green_wait", int'(ok), 1);
    expect_state(8'h20, 2'd1, 3'd2); check_state("s2_r2_green");
    repeat (100) @(negedge clk);
    expect_state(8'h20, 2'd1, 3'd2); check_state("s2_r2_green_hold");

    car_det = 4'b1001;
    wait_state(2'd2, 1'b0, 3'd0, 20, ok);
    check_int("s3_yellow_wait", int'(ok), 1);
    expect_state(8'h10, 2'd2, 3'd2); check_state("s3_r2_yellow");
    measure(2'd2, 40, n); check_int("s3_r2_yellow_len", n, YT * TD);
    expect_state(8'h00, 2'd0, 3'd2); check_state("s3_allred_a");
    measure(2'd0, 40, n); check_int("s3_allred_len_a", n, ART * TD);
    expect_state(8'h80, 2'd1, 3'd3); check_state("s3_r3_green");
    measure(2'd1, 60, n); check_int("s3_r3_green_len", n, MAXG * TD);
    expect_state(8'h40, 2'd2, 3'd3); check_state("s3_r3_yellow");
    measure(2'd2, 40, n); check_int("s3_r3_yellow_len", n, YT * TD);
    expect_state(8'h00, 2'd0, 3'd3); check_state("s3_allred_b");
    measure(2'd0, 40, n); check_int("s3_allred_len_b", n, ART * TD);
    expect_state(8'h02, 2'd1, 3'd0); check_state("s3_r0_green");
    measure(2'd1, 60, n); check_int("s3_r0_green_len", n, MAXG * TD);
    expect_state(8'h01, 2'd2, 3'd0); check_state("s3_r0_yellow");
    measure(2'd2, 40, n); check_int("s3_r0_yellow_len", n, YT * TD);
    expect_state(8'h00, 2'd0, 3'd0); check_state("s3_allred_c");
    measure(2'd0, 40, n); check_int("s3_allred_len_c", n, ART * TD);
    expect_state(8'h80, 2'd1, 3'd3); check_state("s3_r3_green_again");

    car_det = 4'b0010;
    wait_state(2'd1, 1'b1, 3'd1, 200, ok);
    check_int("s4_r1_green_wait", int'(ok), 1);
    expect_state(8'h08, 2'd1, 3'd1); check_state("s4_r1_green");
    car_det = 4'b0110;
    n = 1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (phase !== 2'd1) break;
      n++;
      if (n == 4) car_det = 4'b0100;
    end
    check_int("s4_min_green_len", n, MING * TD);
    expect_state(8'h04, 2'd2, 3'd1); check_state("s4_r1_yellow");

    car_det = 4'b1010;
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    expect_state(8'h00, 2'd0, 3'd3); check_state("s5_async_reset");
    @(negedge clk);
    rst = 1'b1;
    wait_state(2'd1, 1'b0, 3'd0, 40, ok);
    check_int("s5_restart_wait", int'(ok), 1);
    expect_state(8'h08, 2'd1, 3'd1); check_state("s5_restart_r1");

    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
